serial_compare_controller: RTL

SERIAL_COMPARE_CONTROLLER -- requirements
Module: serial_compare_controller

---
 rtl/serial_compare_if.sv | 29 ++
 rtl/serial_compare_controller.sv | 123 ++++++++++++
 2 files changed

// File: rtl/serial_compare_if.sv
// Handshake and result bundle for the serial magnitude comparator.
// The slave modport is the comparator's view; the master modport is the
// producer/consumer side that drives operands and accepts results.
interface serial_compare_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic             a_less_b;
    logic             a_eq_b;
    logic             a_greater_b;
    logic [CW-1:0]    bits_used;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, a_less_b, a_eq_b, a_greater_b, bits_used
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, a_less_b, a_eq_b, a_greater_b, bits_used
    );
endinterface

// File: rtl/serial_compare_controller.sv
// Bit-serial unsigned magnitude comparator. An accepted operand pair is
// walked MSB-first one bit pair per clock; the first differing pair decides
// the relation, which then stays fixed. With EARLY_EXIT the walk stops at
// that first difference, otherwise all WIDTH pairs are consumed. The result
// is held in DONE until the consumer takes it.
module serial_compare_controller #(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 1
) (
    input logic             clk,
    input logic             rst,
    serial_compare_if.slave bus
);
    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
    typedef enum logic [1:0] {REL_EQ, REL_LT, REL_GT} rel_e;

    state_e           state_q, state_d;
    rel_e             rel_q, rel_d;
    rel_e             rel_step;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_bit;
    logic             first_diff;

    // Relation after consuming the current MSB pair; sticky once decided.
    always_comb begin
        rel_step = rel_q;
        if (rel_q == REL_EQ) begin
            if (!a_q[WIDTH-1] && b_q[WIDTH-1]) begin
                rel_step = REL_LT;
            end else if (a_q[WIDTH-1] && !b_q[WIDTH-1]) begin
                rel_step = REL_GT;
            end
        end
        last_bit   = (cnt_q == LAST_IDX);
        first_diff = (EARLY_EXIT != 0) && (rel_q == REL_EQ) && (rel_step != REL_EQ);
    end

    // State register with synchronous active-low reset.
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand shift registers, relation and bit counter; all cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            rel_q <= REL_EQ;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            rel_q <= rel_d;
            cnt_q <= cnt_d;
        end
    end

    // Next-state logic: accept in IDLE, leave SHIFT on LSB or first difference.
    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned, which would infer a latch.
        state_d = state_q;
        case (state_q)
            IDLE:  if (bus.in_valid) state_d = SHIFT;
            SHIFT: if (last_bit || first_diff) state_d = DONE;
            DONE:  if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: capture on accept, shift and count in SHIFT.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        rel_d = rel_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d   = bus.a;
                    b_d   = bus.b;
                    rel_d = REL_EQ;
                    cnt_d = '0;
                end
            end
            SHIFT: begin
                a_d   = a_q << 1;
                b_d   = b_q << 1;
                rel_d = rel_step;
                cnt_d = cnt_q + CW'(1);
            end
            default: ;
        endcase
    end

    // Moore outputs: results are exposed only in DONE, zero elsewhere.
    always_comb begin
        bus.in_ready    = (state_q == IDLE);
        bus.out_valid   = 1'b0;
        bus.a_less_b    = 1'b0;
        bus.a_eq_b      = 1'b0;
        bus.a_greater_b = 1'b0;
        bus.bits_used   = '0;
        if (state_q == DONE) begin
            bus.out_valid   = 1'b1;
            bus.a_less_b    = (rel_q == REL_LT);
            bus.a_eq_b      = (rel_q == REL_EQ);
            bus.a_greater_b = (rel_q == REL_GT);
            bus.bits_used   = cnt_q;
        end
    end
endmodule
